// File: rtl/matrix_cmd_seq.sv
// matrix_cmd_seq
//   Command sequencer in front of the matrix stack controller. It turns
//   GL-style matrix commands (LoadIdentity, LoadMatrix, PushMatrix,
//   PopMatrix, MultMatrix, MatrixMode) into cycle-exact stack enables. It
//   buffers incoming rows, copies the top matrix on push, hands operands to
//   an external 4x4 float multiplier, and tracks the stack depth per mode.
//
// Build option:
//   MATRIX_SEQ_DEPTH_CHECK_EN - when defined, PUSH on a full stack reports
//   overflow and POP at depth 1 reports underflow. When undefined, PUSH and
//   POP always execute and the depth counters wrap modulo 64.
//
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   cmd_valid/cmd_ready        command handshake; cmd_op, cmd_arg (MODE arg)
//   row_valid/row_ready        row stream handshake; row_data (row 0 first)
//   matrix_mode                selected stack (0 modelview, 1 projection)
//   pop_en, load_en,
//   load_id_en, write_en       one-cycle registered stack enables
//   push_en                    always 0 (push is a copy through load_en)
//   data_in                    row streamed to the stack during push
//   write_in_0..3              rows for a top-of-stack write
//   peek_in_0..3               current top-of-stack rows
//   mul_start, mul_a/b_0..3    multiplier request and held operands
//   mul_done, mul_res_0..3     multiplier result
//   busy, err, err_code        status; err_code holds until the next error
//   mv_depth, pj_depth         per-mode stack depth
module matrix_cmd_seq #(
  parameter int MV_DEPTH = 32,
  parameter int PJ_DEPTH = 2,
  parameter int DW       = 128
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  input  logic [2:0]    cmd_op,
  input  logic          cmd_arg,
  output logic          cmd_ready,
  input  logic          row_valid,
  output logic          row_ready,
  input  logic [DW-1:0] row_data,
  output logic          matrix_mode,
  output logic          pop_en,
  output logic          load_en,
  output logic          load_id_en,
  output logic          write_en,
  output logic          push_en,
  output logic [DW-1:0] data_in,
  output logic [DW-1:0] write_in_0,
  output logic [DW-1:0] write_in_1,
  output logic [DW-1:0] write_in_2,
  output logic [DW-1:0] write_in_3,
  input  logic [DW-1:0] peek_in_0,
  input  logic [DW-1:0] peek_in_1,
  input  logic [DW-1:0] peek_in_2,
  input  logic [DW-1:0] peek_in_3,
  output logic          mul_start,
  output logic [DW-1:0] mul_a_0,
  output logic [DW-1:0] mul_a_1,
  output logic [DW-1:0] mul_a_2,
  output logic [DW-1:0] mul_a_3,
  output logic [DW-1:0] mul_b_0,
  output logic [DW-1:0] mul_b_1,
  output logic [DW-1:0] mul_b_2,
  output logic [DW-1:0] mul_b_3,
  input  logic          mul_done,
  input  logic [DW-1:0] mul_res_0,
  input  logic [DW-1:0] mul_res_1,
  input  logic [DW-1:0] mul_res_2,
  input  logic [DW-1:0] mul_res_3,
  output logic          busy,
  output logic          err,
  output logic [1:0]    err_code,
  output logic [5:0]    mv_depth,
  output logic [5:0]    pj_depth
);

  localparam logic [2:0] OP_NOP = 3'd0, OP_LOAD_ID = 3'd1, OP_LOAD = 3'd2,
                         OP_PUSH = 3'd3, OP_POP = 3'd4, OP_MULT = 3'd5,
                         OP_MODE = 3'd6;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0, S_LOAD_ID = 4'd1, S_PUSH0 = 4'd2, S_PUSH1 = 4'd3,
    S_PUSH2 = 4'd4, S_PUSH3 = 4'd5, S_GATHER = 4'd6, S_MUL_REQ = 4'd7,
    S_MUL_WAIT = 4'd8, S_WRITE = 4'd9
  } state_t;

  state_t        state_r, state_s;
  logic [1:0]    idx_r, idx_s;
  logic          is_mult_r, is_mult_s;
  logic          mode_r, mode_s;
  logic [5:0]    mv_depth_r, mv_depth_s, pj_depth_r, pj_depth_s, depth_cur_s;
  logic          err_r, err_s;
  logic [1:0]    err_code_r, err_code_s;
  logic          pop_r, pop_s, load_r, load_s, load_id_r, load_id_s;
  logic          write_r, write_s, start_r, start_s;
  logic [DW-1:0] data_in_r, data_in_s;
  logic          copy_lat_s, a_lat_s, row_wr_s, wr_buf_s, wr_res_s, ovf_s, unf_s;
  logic [DW-1:0] peek_s [4];
  logic [DW-1:0] res_s [4];
  logic [DW-1:0] copy_r [4];
  logic [DW-1:0] row_buf_r [4];
  logic [DW-1:0] mul_a_r [4];
  logic [DW-1:0] write_in_r [4];

  assign peek_s[0] = peek_in_0;  assign peek_s[1] = peek_in_1;
  assign peek_s[2] = peek_in_2;  assign peek_s[3] = peek_in_3;
  assign res_s[0]  = mul_res_0;  assign res_s[1]  = mul_res_1;
  assign res_s[2]  = mul_res_2;  assign res_s[3]  = mul_res_3;

  assign depth_cur_s = mode_r ? pj_depth_r : mv_depth_r;

`ifdef MATRIX_SEQ_DEPTH_CHECK_EN
  logic [5:0] cap_s;
  assign cap_s = mode_r ? 6'(PJ_DEPTH) : 6'(MV_DEPTH);
  assign ovf_s = (depth_cur_s == cap_s);
  assign unf_s = (depth_cur_s == 6'd1);
`else
  // Capacities only matter when depth checking is built in.
  logic [11:0] unused_cap_s;
  assign unused_cap_s = {6'(PJ_DEPTH), 6'(MV_DEPTH)} ^ {depth_cur_s, depth_cur_s};
  assign ovf_s = 1'b0;
  assign unf_s = 1'b0;
`endif

  // Next-state, next-enable and datapath strobe decode.
  always_comb begin
    state_s = state_r;       idx_s = idx_r;         is_mult_s = is_mult_r;
    mode_s = mode_r;         mv_depth_s = mv_depth_r; pj_depth_s = pj_depth_r;
    err_s = 1'b0;            err_code_s = err_code_r;
    pop_s = 1'b0;            load_s = 1'b0;         load_id_s = 1'b0;
    write_s = 1'b0;          start_s = 1'b0;        data_in_s = data_in_r;
    copy_lat_s = 1'b0;       a_lat_s = 1'b0;        row_wr_s = 1'b0;
    wr_buf_s = 1'b0;         wr_res_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            OP_NOP:     state_s = S_IDLE;
            OP_MODE:    mode_s = cmd_arg;
            OP_LOAD_ID: begin state_s = S_LOAD_ID; load_id_s = 1'b1; end
            OP_LOAD:    begin state_s = S_GATHER; idx_s = 2'd0; is_mult_s = 1'b0; end
            OP_MULT:    begin state_s = S_GATHER; idx_s = 2'd0; is_mult_s = 1'b1; end
            OP_PUSH: begin
              if (ovf_s) begin
                err_s = 1'b1; err_code_s = 2'd1;
              end else begin
                // Row 0 goes straight out while the copy buffer captures all rows.
                state_s = S_PUSH0; load_s = 1'b1; copy_lat_s = 1'b1; data_in_s = peek_in_0;
              end
            end
            OP_POP: begin
              if (unf_s) begin
                err_s = 1'b1; err_code_s = 2'd2;
              end else begin
                pop_s = 1'b1;
                if (mode_r) pj_depth_s = pj_depth_r - 6'd1;
                else        mv_depth_s = mv_depth_r - 6'd1;
              end
            end
            default: begin err_s = 1'b1; err_code_s = 2'd3; end
          endcase
        end else begin
          state_s = S_IDLE;
        end
      end
      S_LOAD_ID: state_s = S_IDLE;
      S_PUSH0:   begin state_s = S_PUSH1; data_in_s = copy_r[1]; end
      S_PUSH1:   begin state_s = S_PUSH2; data_in_s = copy_r[2]; end
      S_PUSH2:   begin state_s = S_PUSH3; data_in_s = copy_r[3]; end
      S_PUSH3: begin
        state_s = S_IDLE;
        if (mode_r) pj_depth_s = pj_depth_r + 6'd1;
        else        mv_depth_s = mv_depth_r + 6'd1;
      end
      S_GATHER: begin
        if (row_valid) begin
          row_wr_s = 1'b1;
          if (idx_r == 2'd3) begin
            idx_s = 2'd0;
            if (is_mult_r) begin
              state_s = S_MUL_REQ;
            end else begin
              state_s = S_WRITE; write_s = 1'b1; wr_buf_s = 1'b1;
            end
          end else begin
            idx_s = idx_r + 2'd1;
          end
        end else begin
          state_s = S_GATHER;
        end
      end
      S_MUL_REQ: begin state_s = S_MUL_WAIT; start_s = 1'b1; a_lat_s = 1'b1; end
      S_MUL_WAIT: begin
        if (mul_done) begin
          state_s = S_WRITE; write_s = 1'b1; wr_res_s = 1'b1;
        end else begin
          state_s = S_MUL_WAIT;
        end
      end
      S_WRITE: state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // Control state, enables, mode, depths and error status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;   idx_r <= 2'd0;      is_mult_r <= 1'b0;
      mode_r <= 1'b0;      mv_depth_r <= 6'd1; pj_depth_r <= 6'd1;
      err_r <= 1'b0;       err_code_r <= 2'd0;
      pop_r <= 1'b0;       load_r <= 1'b0;     load_id_r <= 1'b0;
      write_r <= 1'b0;     start_r <= 1'b0;    data_in_r <= '0;
    end else begin
      state_r <= state_s;  idx_r <= idx_s;     is_mult_r <= is_mult_s;
      mode_r <= mode_s;    mv_depth_r <= mv_depth_s; pj_depth_r <= pj_depth_s;
      err_r <= err_s;      err_code_r <= err_code_s;
      pop_r <= pop_s;      load_r <= load_s;   load_id_r <= load_id_s;
      write_r <= write_s;  start_r <= start_s; data_in_r <= data_in_s;
    end
  end

  // Row, copy, operand and write-data storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        copy_r[i] <= '0; row_buf_r[i] <= '0; mul_a_r[i] <= '0; write_in_r[i] <= '0;
      end
    end else begin
      if (copy_lat_s) begin
        for (int i = 0; i < 4; i++) copy_r[i] <= peek_s[i];
      end
      if (row_wr_s) row_buf_r[idx_r] <= row_data;
      if (a_lat_s) begin
        for (int i = 0; i < 4; i++) mul_a_r[i] <= peek_s[i];
      end
      // Row 3 is taken from the bus since it lands in the buffer on this same edge.
      if (wr_buf_s) begin
        write_in_r[0] <= row_buf_r[0]; write_in_r[1] <= row_buf_r[1];
        write_in_r[2] <= row_buf_r[2]; write_in_r[3] <= row_data;
      end else if (wr_res_s) begin
        for (int i = 0; i < 4; i++) write_in_r[i] <= res_s[i];
      end
    end
  end

  assign cmd_ready   = (state_r == S_IDLE);
  assign row_ready   = (state_r == S_GATHER);
  assign busy        = (state_r != S_IDLE);
  assign matrix_mode = mode_r;
  assign pop_en      = pop_r;
  assign load_en     = load_r;
  assign load_id_en  = load_id_r;
  assign write_en    = write_r;
  assign push_en     = 1'b0;
  assign mul_start   = start_r;
  assign data_in     = data_in_r;
  assign err         = err_r;
  assign err_code    = err_code_r;
  assign mv_depth    = mv_depth_r;
  assign pj_depth    = pj_depth_r;
  assign write_in_0 = write_in_r[0]; assign write_in_1 = write_in_r[1];
  assign write_in_2 = write_in_r[2]; assign write_in_3 = write_in_r[3];
  assign mul_a_0 = mul_a_r[0]; assign mul_a_1 = mul_a_r[1];
  assign mul_a_2 = mul_a_r[2]; assign mul_a_3 = mul_a_r[3];
  assign mul_b_0 = row_buf_r[0]; assign mul_b_1 = row_buf_r[1];
  assign mul_b_2 = row_buf_r[2]; assign mul_b_3 = row_buf_r[3];

endmodule

// File: tb/tb_matrix_cmd_seq.sv
module tb_matrix_cmd_seq;
  localparam int DW = 128;

  logic clk = 1'b0, rst_n = 1'b0;
  logic cmd_valid = 1'b0, cmd_arg = 1'b0, cmd_ready;
  logic [2:0] cmd_op = 3'd0;
  logic row_valid = 1'b0, row_ready;
  logic [DW-1:0] row_data = '0;
  logic matrix_mode, pop_en, load_en, load_id_en, write_en, push_en;
  logic [DW-1:0] data_in, write_in_0, write_in_1, write_in_2, write_in_3;
  logic [DW-1:0] peek_in_0 = '0, peek_in_1 = '0, peek_in_2 = '0, peek_in_3 = '0;
  logic mul_start, mul_done = 1'b0;
  logic [DW-1:0] mul_a_0, mul_a_1, mul_a_2, mul_a_3, mul_b_0, mul_b_1, mul_b_2, mul_b_3;
  logic [DW-1:0] mul_res_0 = '0, mul_res_1 = '0, mul_res_2 = '0, mul_res_3 = '0;
  logic busy, err;
  logic [1:0] err_code;
  logic [5:0] mv_depth, pj_depth;

  int pass_cnt = 0;
  int total_cnt = 0;

  matrix_cmd_seq #(.MV_DEPTH(32), .PJ_DEPTH(2), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_arg(cmd_arg),
    .cmd_ready(cmd_ready), .row_valid(row_valid), .row_ready(row_ready), .row_data(row_data),
    .matrix_mode(matrix_mode), .pop_en(pop_en), .load_en(load_en), .load_id_en(load_id_en),
    .write_en(write_en), .push_en(push_en), .data_in(data_in),
    .write_in_0(write_in_0), .write_in_1(write_in_1), .write_in_2(write_in_2), .write_in_3(write_in_3),
    .peek_in_0(peek_in_0), .peek_in_1(peek_in_1), .peek_in_2(peek_in_2), .peek_in_3(peek_in_3),
    .mul_start(mul_start), .mul_a_0(mul_a_0), .mul_a_1(mul_a_1), .mul_a_2(mul_a_2), .mul_a_3(mul_a_3),
    .mul_b_0(mul_b_0), .mul_b_1(mul_b_1), .mul_b_2(mul_b_2), .mul_b_3(mul_b_3),
    .mul_done(mul_done), .mul_res_0(mul_res_0), .mul_res_1(mul_res_1), .mul_res_2(mul_res_2),
    .mul_res_3(mul_res_3), .busy(busy), .err(err), .err_code(err_code),
    .mv_depth(mv_depth), .pj_depth(pj_depth)
  );

  always #5 clk = ~clk;

  // Offer one command for one cycle; returns at the negedge after acceptance.
  task automatic do_cmd(input logic [2:0] op, input logic arg);
    cmd_valid = 1'b1; cmd_op = op; cmd_arg = arg;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_op = 3'd0; cmd_arg = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [5:0] en_v;
    rst_n = 1'b0;
    wait_cycles(3);
    en_v = {pop_en, load_en, load_id_en, write_en, push_en, mul_start};
    total_cnt++; if (en_v !== 6'd0) $display("FAIL reset_enables got=%b exp=000000", en_v); else pass_cnt++;
    total_cnt++; if ({cmd_ready, row_ready, busy, matrix_mode} !== 4'b1000)
      $display("FAIL reset_status got=%b exp=1000", {cmd_ready, row_ready, busy, matrix_mode}); else pass_cnt++;
    total_cnt++; if ({mv_depth, pj_depth, err, err_code} !== {6'd1, 6'd1, 1'b0, 2'd0})
      $display("FAIL reset_depth_err got mv=%0d pj=%0d err=%b code=%0d exp 1 1 0 0", mv_depth, pj_depth, err, err_code); else pass_cnt++;
    rst_n = 1'b1;
    wait_cycles(1);
  endtask

  task automatic test_load_id();
    do_cmd(3'd1, 1'b0);
    total_cnt++; if ({load_id_en, cmd_ready, busy} !== 3'b101)
      $display("FAIL load_id_pulse got=%b exp=101", {load_id_en, cmd_ready, busy}); else pass_cnt++;
    wait_cycles(1);
    total_cnt++; if ({load_id_en, cmd_ready} !== 2'b01)
      $display("FAIL load_id_done got=%b exp=01", {load_id_en, cmd_ready}); else pass_cnt++;
  endtask

  task automatic test_push_mv();
    logic [DW-1:0] id_rows [4];
    int low_cnt;
    id_rows[0] = {32'h3F800000, 32'h0, 32'h0, 32'h0};
    id_rows[1] = {32'h0, 32'h3F800000, 32'h0, 32'h0};
    id_rows[2] = {32'h0, 32'h0, 32'h3F800000, 32'h0};
    id_rows[3] = {32'h0, 32'h0, 32'h0, 32'h3F800000};
    do_cmd(3'd6, 1'b0);
    peek_in_0 = id_rows[0]; peek_in_1 = id_rows[1]; peek_in_2 = id_rows[2]; peek_in_3 = id_rows[3];
    do_cmd(3'd3, 1'b0);
    // The copy must have been taken at accept; later peek changes are ignored.
    peek_in_0 = '1; peek_in_1 = '1; peek_in_2 = '1; peek_in_3 = '1;
    low_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      if (!cmd_ready) low_cnt++;
      total_cnt++; if (load_en !== (k == 0))
        $display("FAIL push_load_en_row%0d got=%b exp=%b", k, load_en, (k == 0)); else pass_cnt++;
      total_cnt++; if (data_in !== id_rows[k])
        $display("FAIL push_data_in_row%0d got=%h exp=%h", k, data_in, id_rows[k]); else pass_cnt++;
      wait_cycles(1);
    end
    total_cnt++; if (low_cnt !== 4) $display("FAIL push_ready_low got=%0d exp=4", low_cnt); else pass_cnt++;
    total_cnt++; if ({cmd_ready, mv_depth} !== {1'b1, 6'd2})
      $display("FAIL push_mv_depth got ready=%b mv=%0d exp 1 2", cmd_ready, mv_depth); else pass_cnt++;
  endtask

  task automatic test_proj_stack();
    do_cmd(3'd6, 1'b1);
    total_cnt++; if (matrix_mode !== 1'b1) $display("FAIL mode_proj got=%b exp=1", matrix_mode); else pass_cnt++;
    do_cmd(3'd3, 1'b0);
    wait_cycles(4);
    total_cnt++; if (pj_depth !== 6'd2) $display("FAIL pj_push1 got=%0d exp=2", pj_depth); else pass_cnt++;
    do_cmd(3'd3, 1'b0);
`ifdef MATRIX_SEQ_DEPTH_CHECK_EN
    total_cnt++; if ({err, err_code, load_en, cmd_ready} !== {1'b1, 2'd1, 1'b0, 1'b1})
      $display("FAIL pj_overflow got err=%b code=%0d load=%b rdy=%b exp 1 1 0 1", err, err_code, load_en, cmd_ready); else pass_cnt++;
    wait_cycles(1);
    total_cnt++; if ({err, pj_depth} !== {1'b0, 6'd2})
      $display("FAIL pj_overflow_after got err=%b pj=%0d exp 0 2", err, pj_depth); else pass_cnt++;
    do_cmd(3'd4, 1'b0);
    total_cnt++; if ({pop_en, pj_depth} !== {1'b1, 6'd1})
      $display("FAIL pj_pop1 got pop=%b pj=%0d exp 1 1", pop_en, pj_depth); else pass_cnt++;
    do_cmd(3'd4, 1'b0);
    total_cnt++; if ({err, err_code, pop_en, pj_depth} !== {1'b1, 2'd2, 1'b0, 6'd1})
      $display("FAIL pj_underflow got err=%b code=%0d pop=%b pj=%0d exp 1 2 0 1", err, err_code, pop_en, pj_depth); else pass_cnt++;
`else
    total_cnt++; if ({err, load_en} !== 2'b01)
      $display("FAIL pj_push2_nocheck got err=%b load=%b exp 0 1", err, load_en); else pass_cnt++;
    wait_cycles(4);
    total_cnt++; if (pj_depth !== 6'd3) $display("FAIL pj_push2_depth got=%0d exp=3", pj_depth); else pass_cnt++;
    do_cmd(3'd4, 1'b0);
    total_cnt++; if ({pop_en, pj_depth} !== {1'b1, 6'd2})
      $display("FAIL pj_pop1 got pop=%b pj=%0d exp 1 2", pop_en, pj_depth); else pass_cnt++;
    do_cmd(3'd4, 1'b0);
    total_cnt++; if ({err, pop_en, pj_depth} !== {1'b0, 1'b1, 6'd1})
      $display("FAIL pj_pop2 got err=%b pop=%b pj=%0d exp 0 1 1", err, pop_en, pj_depth); else pass_cnt++;
`endif
    wait_cycles(1);
    total_cnt++; if ({pop_en, mv_depth} !== {1'b0, 6'd2})
      $display("FAIL mv_untouched got pop=%b mv=%0d exp 0 2", pop_en, mv_depth); else pass_cnt++;
    do_cmd(3'd6, 1'b0);
  endtask

  task automatic test_load_gapped();
    logic [DW-1:0] rows [4];
    int we_cnt;
    rows[0] = {4{32'h11111111}}; rows[1] = {4{32'h22222222}};
    rows[2] = {4{32'h33333333}}; rows[3] = {4{32'h44444444}};
    we_cnt = 0;
    do_cmd(3'd2, 1'b0);
    total_cnt++; if ({row_ready, cmd_ready} !== 2'b10)
      $display("FAIL load_gather got=%b exp=10", {row_ready, cmd_ready}); else pass_cnt++;
    for (int r = 0; r < 4; r++) begin
      for (int g = 0; g < 2; g++) begin
        if (write_en) we_cnt++;
        wait_cycles(1);
      end
      row_valid = 1'b1; row_data = rows[r];
      if (write_en) we_cnt++;
      wait_cycles(1);
      row_valid = 1'b0; row_data = '0;
    end
    if (write_en) we_cnt++;
    total_cnt++; if ({write_in_0, write_in_1, write_in_2, write_in_3} !== {rows[0], rows[1], rows[2], rows[3]})
      $display("FAIL load_write_in got=%h %h %h %h", write_in_0, write_in_1, write_in_2, write_in_3); else pass_cnt++;
    wait_cycles(1);
    if (write_en) we_cnt++;
    total_cnt++; if (we_cnt !== 1) $display("FAIL load_write_en_count got=%0d exp=1", we_cnt); else pass_cnt++;
    total_cnt++; if (cmd_ready !== 1'b1) $display("FAIL load_done_ready got=%b exp=1", cmd_ready); else pass_cnt++;
  endtask

  task automatic test_mult();
    logic [DW-1:0] pk [4];
    logic [DW-1:0] b [4];
    logic [DW-1:0] res [4];
    int bad_hold;
    for (int i = 0; i < 4; i++) begin
      pk[i]  = {4{32'hA0000000 + 32'(i)}};
      b[i]   = {4{32'hB0000000 + 32'(i)}};
      res[i] = {4{32'hC0000000 + 32'(i)}};
    end
    peek_in_0 = pk[0]; peek_in_1 = pk[1]; peek_in_2 = pk[2]; peek_in_3 = pk[3];
    do_cmd(3'd5, 1'b0);
    for (int r = 0; r < 4; r++) begin
      row_valid = 1'b1; row_data = b[r];
      wait_cycles(1);
    end
    row_valid = 1'b0; row_data = '0;
    total_cnt++; if ({mul_start, row_ready, busy} !== 3'b001)
      $display("FAIL mult_req got=%b exp=001", {mul_start, row_ready, busy}); else pass_cnt++;
    wait_cycles(1);
    total_cnt++; if (mul_start !== 1'b1) $display("FAIL mult_start got=%b exp=1", mul_start); else pass_cnt++;
    total_cnt++; if ({mul_a_0, mul_a_1, mul_a_2, mul_a_3} !== {pk[0], pk[1], pk[2], pk[3]})
      $display("FAIL mult_a got=%h %h %h %h", mul_a_0, mul_a_1, mul_a_2, mul_a_3); else pass_cnt++;
    total_cnt++; if ({mul_b_0, mul_b_1, mul_b_2, mul_b_3} !== {b[0], b[1], b[2], b[3]})
      $display("FAIL mult_b got=%h %h %h %h", mul_b_0, mul_b_1, mul_b_2, mul_b_3); else pass_cnt++;
    peek_in_0 = '0; peek_in_1 = '0; peek_in_2 = '0; peek_in_3 = '0;
    bad_hold = 0;
    for (int k = 0; k < 7; k++) begin
      wait_cycles(1);
      if (mul_start || write_en || !busy) bad_hold++;
      if ({mul_a_0, mul_a_1, mul_a_2, mul_a_3, mul_b_0, mul_b_1, mul_b_2, mul_b_3} !==
          {pk[0], pk[1], pk[2], pk[3], b[0], b[1], b[2], b[3]}) bad_hold++;
    end
    total_cnt++; if (bad_hold !== 0) $display("FAIL mult_wait_hold got=%0d bad cycles exp=0", bad_hold); else pass_cnt++;
    mul_done = 1'b1;
    mul_res_0 = res[0]; mul_res_1 = res[1]; mul_res_2 = res[2]; mul_res_3 = res[3];
    wait_cycles(1);
    mul_done = 1'b0;
    mul_res_0 = '0; mul_res_1 = '0; mul_res_2 = '0; mul_res_3 = '0;
    total_cnt++; if (write_en !== 1'b1) $display("FAIL mult_write_en got=%b exp=1", write_en); else pass_cnt++;
    total_cnt++; if ({write_in_0, write_in_1, write_in_2, write_in_3} !== {res[0], res[1], res[2], res[3]})
      $display("FAIL mult_write_in got=%h %h %h %h", write_in_0, write_in_1, write_in_2, write_in_3); else pass_cnt++;
    wait_cycles(1);
    total_cnt++; if ({write_en, cmd_ready} !== 2'b01)
      $display("FAIL mult_done got=%b exp=01", {write_en, cmd_ready}); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    peek_in_0 = {4{32'h55555555}}; peek_in_1 = peek_in_0; peek_in_2 = peek_in_0; peek_in_3 = peek_in_0;
    do_cmd(3'd3, 1'b0);
    wait_cycles(2);
    rst_n = 1'b0;
    #1;
    total_cnt++; if ({load_en, busy, cmd_ready, mv_depth, data_in} !== {1'b0, 1'b0, 1'b1, 6'd1, 128'd0})
      $display("FAIL reset_mid got load=%b busy=%b rdy=%b mv=%0d data=%h", load_en, busy, cmd_ready, mv_depth, data_in); else pass_cnt++;
    wait_cycles(1);
    rst_n = 1'b1;
    wait_cycles(3);
    total_cnt++; if ({load_en, busy, mv_depth} !== {1'b0, 1'b0, 6'd1})
      $display("FAIL reset_mid_after got load=%b busy=%b mv=%0d", load_en, busy, mv_depth); else pass_cnt++;
  endtask

  task automatic test_bad_op();
    do_cmd(3'd7, 1'b0);
    total_cnt++; if ({err, err_code, pop_en, load_en, load_id_en, write_en, busy} !== {1'b1, 2'd3, 5'd0})
      $display("FAIL bad_op got err=%b code=%0d busy=%b", err, err_code, busy); else pass_cnt++;
    wait_cycles(1);
    total_cnt++; if ({err, err_code} !== {1'b0, 2'd3})
      $display("FAIL bad_op_hold got err=%b code=%0d exp 0 3", err, err_code); else pass_cnt++;
  endtask

  task automatic test_depth_limit();
    int err_seen;
    err_seen = 0;
`ifdef MATRIX_SEQ_DEPTH_CHECK_EN
    for (int p = 0; p < 31; p++) begin
      do_cmd(3'd3, 1'b0);
      if (err) err_seen++;
      wait_cycles(4);
    end
    total_cnt++; if ({err_seen, mv_depth} !== {32'd0, 6'd32})
      $display("FAIL mv_fill got errs=%0d mv=%0d exp 0 32", err_seen, mv_depth); else pass_cnt++;
    do_cmd(3'd3, 1'b0);
    total_cnt++; if ({err, err_code, load_en, mv_depth} !== {1'b1, 2'd1, 1'b0, 6'd32})
      $display("FAIL mv_overflow got err=%b code=%0d load=%b mv=%0d", err, err_code, load_en, mv_depth); else pass_cnt++;
`else
    for (int p = 0; p < 33; p++) begin
      do_cmd(3'd3, 1'b0);
      if (err) err_seen++;
      wait_cycles(4);
    end
    total_cnt++; if ({err_seen, mv_depth, err_code} !== {32'd0, 6'd34, 2'd3})
      $display("FAIL mv_33_push got errs=%0d mv=%0d code=%0d exp 0 34 3", err_seen, mv_depth, err_code); else pass_cnt++;
`endif
  endtask

  initial begin
    test_reset();
    test_load_id();
    test_push_mv();
    test_proj_stack();
    test_load_gapped();
    test_mult();
    test_reset_mid();
    test_bad_op();
    test_depth_limit();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/matrix_cmd_seq.md
Name: matrix_cmd_seq

Overview:
- Command sequencer in front of the matrix stack controller; turns GL-style matrix commands into cycle-exact `pop_en`/`load_en`/`load_id_en`/`write_en` sequences.
- Commands: LoadIdentity, LoadMatrix, PushMatrix, PopMatrix, MultMatrix, MatrixMode.
- Buffers incoming rows, copies the top matrix on push, hands operands to an external 4x4 float multiplier, and tracks stack depth per mode.

Parameters:
- MV_DEPTH, 32, modelview stack capacity in matrices (identity preloaded = depth 1).
- PJ_DEPTH, 2, projection stack capacity in matrices.
- DW, 128, row width (4 x fp32).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_op  in  3  0 NOP, 1 LOAD_ID, 2 LOAD, 3 PUSH, 4 POP, 5 MULT, 6 MODE.
- cmd_arg  in  1  MODE argument: 0 modelview, 1 projection.
- cmd_ready  out  1  command accepted when valid & ready.
- row_valid / row_ready  in/out  1  row stream handshake (LOAD, MULT operands).
- row_data  in  DW  row, row 0 first.
- matrix_mode  out  1  to stack controller.
- pop_en, load_en, load_id_en, write_en  out  1  to stack controller.
- push_en  out  1  tied 0 (push is done via `load_en`).
- data_in  out  DW  row for stack load.
- write_in_0..3  out  DW  rows for top-of-stack write.
- peek_in_0..3  in  DW  top-of-stack rows from stack controller.
- mul_start  out  1  one-cycle pulse, operands valid.
- mul_a_0..3, mul_b_0..3  out  DW  A = latched top rows, B = row buffer.
- mul_done  in  1  result valid pulse.
- mul_res_0..3  in  DW  product rows (sampled on `mul_done`).
- busy  out  1  state != IDLE.
- err  out  1  one-cycle pulse on rejected command.
- err_code  out  2  1 overflow, 2 underflow, 3 bad op; held until next err.
- mv_depth, pj_depth  out  6  current depth per stack.

Behaviour:
- Reset (asynchronous, active-low): state IDLE; all enables 0; `matrix_mode` 0; `mv_depth` = 1; `pj_depth` = 1; `err` = 0; `err_code` = 0; row buffer and latches 0; `cmd_ready` = 1.
- Reset asserted mid-sequence: sequence is abandoned with no further enables. The stack controller has no reset; system reset is required to assert both together.
- `cmd_ready` = 1 only in IDLE. `row_ready` = 1 only in GATHER.
- Enables are registered outputs. Each enable is high for exactly 1 cycle per use. `matrix_mode` never changes while `busy` is high.
- IDLE, on accept:
  - NOP: stay in IDLE.
  - MODE: `matrix_mode` <= `cmd_arg` next cycle.
  - LOAD_ID: `load_id_en` = 1 next cycle, then IDLE (2-cycle occupancy).
  - POP: if depth == 1, err underflow, no enable. Else `pop_en` = 1 next cycle, depth - 1.
  - PUSH: if depth == capacity, err overflow. Else latch `peek_in_0..3` into the copy buffer and go to PUSH0.
  - LOAD, MULT: go to GATHER, row index 0.
  - ops 7: err bad op.
- PUSH0..PUSH3: `data_in` = copy row k in each state. `load_en` = 1 only in PUSH0. Exit to IDLE after PUSH3; depth + 1. Total 5 cycles from accept to `cmd_ready`.
- GATHER: store `row_data` into buffer[idx] on each row handshake. Rows may stall indefinitely. After row 3:
  - LOAD goes to WRITE with `write_in` = buffer.
  - MULT goes to MUL_REQ.
- MUL_REQ: latch `peek_in_0..3` into A, pulse `mul_start`, go to MUL_WAIT. `mul_a`/`mul_b` are held stable until `mul_done`.
- MUL_WAIT: on `mul_done`, capture `mul_res` into `write_in`, go to WRITE. Other commands wait.
- WRITE: `write_en` = 1 for 1 cycle, then IDLE.
- Depth counters are independent per mode and are updated by the mode current at accept.
- Error has no side effects: `err` pulses 1 cycle after accept; state returns to IDLE.

Optional Feature:
- MATRIX_SEQ_DEPTH_CHECK_EN:
  - Defined: overflow/underflow checks as above.
  - Undefined: PUSH/POP always execute, depth counters wrap modulo 64, `err_code` 1/2 never produced (bad op still reported).

Test Plan:
- Reset, MODE 0, PUSH with peek = identity rows -> `load_en` single cycle; `data_in` = 3F800000_0.., then rows 1..3 on the following 3 cycles; `mv_depth` 1->2; `cmd_ready` low 4 cycles.
- MODE 1, PUSH, PUSH -> first succeeds (`pj_depth` 2), second gives `err` = 1 with `err_code` = 1 and no `load_en`; POP twice -> second gives underflow, `pj_depth` = 1.
- LOAD with rows 0x1111.., 0x2222.., 0x3333.., 0x4444.., `row_valid` gapped 2 cycles between rows -> single `write_en`; `write_in_0..3` match in order.
- MULT with operand rows B; `mul_done` 7 cycles after `mul_start` -> `mul_a` = peek, `mul_b` = B held stable; `write_en` 1 cycle after `mul_done` with `write_in` = `mul_res`.
- `rst_n` low during PUSH2 -> all enables 0 immediately, IDLE, depths back to 1.
- `cmd_op` = 7 -> `err_code` = 3, no enables; with macro undefined, 33 PUSHes -> no err, `mv_depth` = 34.
